// File: rtl/gpio_input_filter_pkg.sv
// Shared definitions for the GPIO input filter: pin count default and the
// per-pin debounce FSM encoding, also visible as macros to the controller bench.
`ifndef GPIO_NUMS
`define GPIO_NUMS 8
`endif
`ifndef GPIO_FLT_ST_LO
`define GPIO_FLT_ST_LO  2'd0
`define GPIO_FLT_CHK_HI 2'd1
`define GPIO_FLT_ST_HI  2'd2
`define GPIO_FLT_CHK_LO 2'd3
`endif

package gpio_input_filter_pkg;

  localparam int FLT_STATE_W = 2;

  typedef enum logic [FLT_STATE_W-1:0] {
    ST_LO  = `GPIO_FLT_ST_LO,
    CHK_HI = `GPIO_FLT_CHK_HI,
    ST_HI  = `GPIO_FLT_ST_HI,
    CHK_LO = `GPIO_FLT_CHK_LO
  } flt_state_e;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin of the input filter: two-flop synchroniser, debounce FSM with a
// saturating stable-time counter, registered level, edge pulses and sticky pending flag.
module gpio_debounce_cell
  import gpio_input_filter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             gpio_clk,
  input  logic             rst_n,
  input  logic             pad,
  input  logic [CNT_W-1:0] cfg_db_cycles,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             edge_clear,
  output logic             filtered,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             edge_pending
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_p0;
  logic             s2_p1;
  flt_state_e       state_q;
  flt_state_e       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_done;
  logic             rise_evt;
  logic             fall_evt;
  logic             filt_nxt;
  logic             pend_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  // Live compare so a lowered threshold takes effect on the very next edge.
  assign cnt_done = (cnt_q >= min_one(cfg_db_cycles));

  // Stage p0/p1: pad synchroniser
  always_ff @(posedge gpio_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
    end else begin
      s1_p0 <= pad;
      s2_p1 <= s1_p0;
    end
  end

  // Stage p2: debounce FSM and counter
  always_ff @(posedge gpio_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_LO: begin
        if (s2_p1) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s2_p1) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else if (cnt_done) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      ST_HI: begin
        if (!s2_p1) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s2_p1) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else if (cnt_done) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      default: begin
        state_nxt = ST_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    rise_evt = (state_q == CHK_HI) && s2_p1 && cnt_done;
    fall_evt = (state_q == CHK_LO) && !s2_p1 && cnt_done;
    filt_nxt = filtered;
    if (rise_evt) begin
      filt_nxt = 1'b1;
    end else if (fall_evt) begin
      filt_nxt = 1'b0;
    end
    // A set landing together with a clear keeps the flag.
    pend_nxt = (rise_evt & rise_en) | (fall_evt & fall_en) |
               (edge_pending & ~edge_clear);
  end

  // Stage p3: registered outputs
  always_ff @(posedge gpio_clk or negedge rst_n) begin
    if (!rst_n) begin
      filtered     <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      edge_pending <= 1'b0;
    end else begin
      filtered     <= filt_nxt;
      rise_pulse   <= rise_evt & rise_en;
      fall_pulse   <= fall_evt & fall_en;
      edge_pending <= pend_nxt;
    end
  end

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO input conditioner: one debounce cell per pin plus the any-pending summary
// the controller uses as its interrupt source.
`ifndef GPIO_NUMS
`define GPIO_NUMS 8
`endif

module gpio_input_filter #(
  parameter int NUMS  = `GPIO_NUMS,
  parameter int CNT_W = 16
) (
  input  logic             gpio_clk,
  input  logic             rst_n,
  input  logic [NUMS-1:0]  pad_in,
  input  logic [CNT_W-1:0] cfg_db_cycles,
  input  logic [NUMS-1:0]  cfg_rise_en,
  input  logic [NUMS-1:0]  cfg_fall_en,
  input  logic [NUMS-1:0]  edge_clear,
  output logic [NUMS-1:0]  gpio_filtered,
  output logic [NUMS-1:0]  rise_pulse,
  output logic [NUMS-1:0]  fall_pulse,
  output logic [NUMS-1:0]  edge_pending,
  output logic             edge_any
);

  for (genvar i = 0; i < NUMS; i++) begin : g_pin
    gpio_debounce_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .gpio_clk      (gpio_clk),
      .rst_n         (rst_n),
      .pad           (pad_in[i]),
      .cfg_db_cycles (cfg_db_cycles),
      .rise_en       (cfg_rise_en[i]),
      .fall_en       (cfg_fall_en[i]),
      .edge_clear    (edge_clear[i]),
      .filtered      (gpio_filtered[i]),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i]),
      .edge_pending  (edge_pending[i])
    );
  end

  assign edge_any = |edge_pending;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Scoreboard bench for gpio_input_filter: directed pad sequences queue expected
// pulse events and level checks; a negedge monitor matches them against the DUT.
module tb_gpio_input_filter;

  localparam int N = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  pad_in;
  logic [CW-1:0] cfg_db_cycles;
  logic [N-1:0]  cfg_rise_en;
  logic [N-1:0]  cfg_fall_en;
  logic [N-1:0]  edge_clear;
  logic [N-1:0]  gpio_filtered;
  logic [N-1:0]  rise_pulse;
  logic [N-1:0]  fall_pulse;
  logic [N-1:0]  edge_pending;
  logic          edge_any;

  gpio_input_filter #(.NUMS(N), .CNT_W(CW)) dut (
    .gpio_clk      (clk),
    .rst_n         (rst_n),
    .pad_in        (pad_in),
    .cfg_db_cycles (cfg_db_cycles),
    .cfg_rise_en   (cfg_rise_en),
    .cfg_fall_en   (cfg_fall_en),
    .edge_clear    (edge_clear),
    .gpio_filtered (gpio_filtered),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .edge_pending  (edge_pending),
    .edge_any      (edge_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } evt_t;

  typedef struct {
    int         c;
    int         kind;
    logic [N-1:0] v;
  } chk_t;

  evt_t evq[$];
  chk_t ckq[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  function automatic string kind_name(input int k);
    case (k)
      0:       return "filtered";
      1:       return "pending";
      default: return "edge_any";
    endcase
  endfunction

  task automatic exp_evt(input int c, input logic [N-1:0] r, input logic [N-1:0] f);
    evt_t e;
    e.c = c; e.rise = r; e.fall = f;
    evq.push_back(e);
  endtask

  task automatic exp_at(input int c, input int kind, input logic [N-1:0] v);
    chk_t k;
    k.c = c; k.kind = kind; k.v = v;
    ckq.push_back(k);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pulses pop the event queue, level checks fire on their cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        if ((rise_pulse | fall_pulse) != '0) begin
          total++;
          if (evq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse cyc=%0d rise=%02h fall=%02h required=none",
                     cyc, rise_pulse, fall_pulse);
          end else begin
            evt_t e;
            e = evq.pop_front();
            if (e.c != cyc || e.rise != rise_pulse || e.fall != fall_pulse) begin
              bad++;
              $display("FAIL pulse cyc=%0d rise=%02h fall=%02h required cyc=%0d rise=%02h fall=%02h",
                       cyc, rise_pulse, fall_pulse, e.c, e.rise, e.fall);
            end
          end
        end
        for (int i = ckq.size() - 1; i >= 0; i--) begin
          if (ckq[i].c == cyc) begin
            logic [N-1:0] act;
            case (ckq[i].kind)
              0:       act = gpio_filtered;
              1:       act = edge_pending;
              default: act = {{(N-1){1'b0}}, edge_any};
            endcase
            total++;
            if (act !== ckq[i].v) begin
              bad++;
              $display("FAIL %s cyc=%0d actual=%02h required=%02h",
                       kind_name(ckq[i].kind), cyc, act, ckq[i].v);
            end
            ckq.delete(i);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int r;
    rst_n         = 1'b0;
    pad_in        = '0;
    cfg_db_cycles = 16'd4;
    cfg_rise_en   = 8'hBF;
    cfg_fall_en   = 8'hFF;
    edge_clear    = '0;

    // Reset state
    @(negedge clk);
    c = cyc;
    exp_at(c + 1, 0, 8'h00);
    exp_at(c + 1, 1, 8'h00);
    exp_at(c + 1, 2, 8'h00);
    tick(2);
    rst_n = 1'b1;
    c = cyc;
    exp_at(c + 1, 0, 8'h00);
    exp_at(c + 20, 0, 8'h00);
    exp_at(c + 20, 1, 8'h00);
    exp_at(c + 20, 2, 8'h00);
    tick(20);

    // Clean rise on pin 0, D=4
    c = cyc;
    pad_in[0] = 1'b1;
    exp_at(c + 6, 0, 8'h00);
    exp_evt(c + 7, 8'h01, 8'h00);
    exp_at(c + 7, 0, 8'h01);
    exp_at(c + 7, 1, 8'h01);
    exp_at(c + 7, 2, 8'h01);
    tick(10);

    // Bounce on pin 1 is rejected, then a stable rise
    c = cyc;
    pad_in[1] = 1'b1;
    tick(3);
    pad_in[1] = 1'b0;
    exp_at(c + 12, 0, 8'h01);
    exp_at(c + 12, 1, 8'h01);
    tick(12);
    c = cyc;
    pad_in[1] = 1'b1;
    exp_evt(c + 7, 8'h02, 8'h00);
    exp_at(c + 6, 0, 8'h01);
    exp_at(c + 7, 0, 8'h03);
    exp_at(c + 7, 1, 8'h03);
    tick(10);

    // Pin 2: rise, lone clear, then fall colliding with clear
    c = cyc;
    pad_in[2] = 1'b1;
    exp_evt(c + 7, 8'h04, 8'h00);
    exp_at(c + 7, 1, 8'h07);
    tick(9);
    edge_clear[2] = 1'b1;
    exp_at(c + 10, 1, 8'h03);
    exp_at(c + 11, 1, 8'h03);
    tick(1);
    edge_clear[2] = 1'b0;
    tick(2);
    c = cyc;
    pad_in[2] = 1'b0;
    exp_evt(c + 7, 8'h00, 8'h04);
    exp_at(c + 7, 0, 8'h03);
    exp_at(c + 7, 1, 8'h07);
    exp_at(c + 8, 1, 8'h03);
    exp_at(c + 9, 1, 8'h03);
    tick(6);
    edge_clear[2] = 1'b1;
    tick(2);
    edge_clear[2] = 1'b0;
    tick(4);

    // Simultaneous falls on pins 0 and 1, then clear everything
    c = cyc;
    pad_in[1:0] = 2'b00;
    exp_evt(c + 7, 8'h00, 8'h03);
    exp_at(c + 7, 0, 8'h00);
    exp_at(c + 7, 1, 8'h03);
    tick(10);
    c = cyc;
    edge_clear = '1;
    exp_at(c + 1, 1, 8'h00);
    exp_at(c + 1, 2, 8'h00);
    tick(1);
    edge_clear = '0;
    tick(2);

    // D=0 acts as D=1 on pin 4
    cfg_db_cycles = 16'd0;
    c = cyc;
    pad_in[4] = 1'b1;
    exp_at(c + 3, 0, 8'h00);
    exp_evt(c + 4, 8'h10, 8'h00);
    exp_at(c + 4, 0, 8'h10);
    exp_at(c + 4, 1, 8'h10);
    tick(8);

    // D lowered from 100 to 5 with count at 20 on pin 5
    cfg_db_cycles = 16'd100;
    c = cyc;
    pad_in[5] = 1'b1;
    exp_at(c + 22, 0, 8'h10);
    exp_evt(c + 23, 8'h20, 8'h00);
    exp_at(c + 23, 0, 8'h30);
    exp_at(c + 23, 1, 8'h30);
    tick(22);
    cfg_db_cycles = 16'd5;
    tick(4);
    cfg_db_cycles = 16'd4;
    tick(2);

    // Pin 6 has rise events disabled: level moves, no pulse, no pending
    c = cyc;
    pad_in[6] = 1'b1;
    exp_at(c + 6, 0, 8'h30);
    exp_at(c + 7, 0, 8'h70);
    exp_at(c + 7, 1, 8'h30);
    exp_at(c + 8, 1, 8'h30);
    tick(10);

    // Reset during CHK_HI of pin 3, pads 3..6 still high afterwards
    c = cyc;
    pad_in[3] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    exp_at(c + 5, 0, 8'h00);
    exp_at(c + 5, 1, 8'h00);
    exp_at(c + 5, 2, 8'h00);
    tick(2);
    rst_n = 1'b1;
    r = cyc;
    exp_at(r + 6, 0, 8'h00);
    exp_evt(r + 7, 8'h38, 8'h00);
    exp_at(r + 7, 0, 8'h78);
    exp_at(r + 7, 1, 8'h38);
    exp_at(r + 7, 2, 8'h01);
    tick(10);

    done = 1'b1;
    foreach (evq[i]) begin
      total++;
      bad++;
      $display("FAIL missing_pulse required cyc=%0d rise=%02h fall=%02h actual=none",
               evq[i].c, evq[i].rise, evq[i].fall);
    end
    foreach (ckq[i]) begin
      total++;
      bad++;
      $display("FAIL unchecked_%s required cyc=%0d value=%02h actual=never_sampled",
               kind_name(ckq[i].kind), ckq[i].c, ckq[i].v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_input_filter.md
# gpio_input_filter

- Per-pin input conditioner placed between the GPIO pads and the GPIO controller's input path.
- Per pin, it synchronises the raw pad level, debounces it with a programmable stable-time counter, and produces the filtered level plus one-cycle rise/fall event pulses.
- It keeps sticky per-pin edge-pending flags.
- The GPIO controller samples the filtered levels and pending flags instead of raw pads, which removes metastability and bounce-induced spurious interrupts.

## Interface
Parameters:
- `NUMS`, default `` `GPIO_NUMS ``: number of pins.
- `CNT_W`, default 16: debounce counter width.

Ports (one clock; reset is asynchronous and active-low):
- `gpio_clk` input 1: block clock.
- `rst_n` input 1: asynchronous active-low reset.
- `pad_in` input NUMS: raw asynchronous pad levels.
- `cfg_db_cycles` input CNT_W: debounce stable time, in cycles; 0 is treated as 1.
- `cfg_rise_en` input NUMS: per-pin enable for rising-edge events.
- `cfg_fall_en` input NUMS: per-pin enable for falling-edge events.
- `edge_clear` input NUMS: per-pin clear of `edge_pending`.
- `gpio_filtered` output NUMS: debounced level.
- `rise_pulse` output NUMS: one-cycle pulse on a filtered 0→1 transition, when enabled.
- `fall_pulse` output NUMS: one-cycle pulse on a filtered 1→0 transition, when enabled.
- `edge_pending` output NUMS: sticky OR of the enabled rise/fall events.
- `edge_any` output 1: OR-reduction of `edge_pending`.

## Operation
- **Synchroniser:** two flops per pin, `s1` then `s2`. Only `s2` is used downstream.
- **Per-pin FSM states:**
  - `ST_LO`: filtered level is 0.
  - `CHK_HI`: `s2`=1 seen, counting.
  - `ST_HI`: filtered level is 1.
  - `CHK_LO`: `s2`=0 seen, counting.
- **Transitions:**
  - `ST_LO` → `CHK_HI` when `s2`=1; count is loaded with 1.
  - In `CHK_HI` with `s2`=1: count increments. When count ≥ D (D = max(`cfg_db_cycles`, 1)), go to `ST_HI` and set filtered=1.
  - In `CHK_HI` with `s2`=0: return to `ST_LO` and clear the count. This is glitch rejection; no event is produced.
  - `ST_HI`/`CHK_LO` mirror the above with levels inverted.
- **Entering `ST_HI` from `CHK_HI`:**
  - Drive `rise_pulse` for exactly one cycle if `cfg_rise_en` is set.
  - Set `edge_pending` if `cfg_rise_en` is set.
- **Entering `ST_LO` from `CHK_LO`:** `fall_pulse` and `edge_pending` behave the same way, gated by `cfg_fall_en`.
- **D=1 shortcut:** a stable differing `s2` causes the transition at the end of the first `CHK_*` cycle, i.e. one cycle after `s2` changes.
- **Counter saturation:** the counter saturates at 2^CNT_W−1 and never wraps.
- **Live comparison:** `cfg_db_cycles` is compared live. If it is lowered mid-check below the current count, the transition happens on the next clock.
- **Enables are sampled at the transition cycle only:** an enable change does not retroactively create events.
- **`edge_pending` update priority:** a set in the same cycle as `edge_clear` wins, so the flag stays 1. A clear with no concurrent set drops the flag on the next edge.
- **Filtered level vs. events:** `gpio_filtered` follows the FSM regardless of the edge enables.

## Timing
- **Reset values:**
  - All sync flops 0.
  - FSM in `ST_LO`, counters 0.
  - `gpio_filtered`, `rise_pulse`, `fall_pulse`, `edge_pending` all 0; `edge_any` 0.
  - A pad held high through reset therefore produces a rise event 2+D cycles after reset release.
- **Reset asserted mid-check:** immediately returns the pin to reset state; no pulse is emitted.
- **Latency:** pad change sampled at edge k → `s2` at k+2 → `gpio_filtered` and pulse registered at edge k+2+D.
- **Output registration:**
  - All outputs come directly from flops, except `edge_any`, which is a combinational OR of registered flags.
  - Pulses are high for exactly one `gpio_clk` cycle, coincident with the first cycle of the new filtered level.
- **Pin independence:** no cross-pin coupling; simultaneous transitions on different pins are all reported in the same cycle.

## Structure
- `` `GPIO_NUMS `` comes from the shared `config.v`.
- The FSM state encodings (`ST_LO`=2'd0, `CHK_HI`=2'd1, `ST_HI`=2'd2, `CHK_LO`=2'd3) are defined as macros in `config.v` under a `GPIO_FLT_` prefix, so that the controller bench can decode them.
- Sub-module `gpio_debounce_cell` holds one pin's synchroniser, FSM, counter, pulse and pending logic.
- The top instantiates NUMS cells in a generate loop and builds `edge_any`.

## Test plan
1. **Reset:** release reset with `pad_in`=0, D=4; hold 20 cycles → all outputs stay 0, `edge_any`=0.
2. **Clean rise:** `pad_in[0]` 0→1 at cycle 10, D=4, `rise_en[0]`=1 → `gpio_filtered[0]`=1 and `rise_pulse[0]` high for exactly one cycle at cycle 16, `edge_pending[0]`=1, `edge_any`=1.
3. **Bounce:** toggle `pad_in[1]` high for 3 cycles then low, with D=4 → no `gpio_filtered`, pulse or pending change. Then hold high 10 cycles → a single rise event, 6 cycles after the final rising edge.
4. **Set/clear collision:** assert `edge_clear[2]` in the same cycle as a fall event with `fall_en[2]`=1 → `edge_pending[2]` remains 1. A lone `edge_clear` the next cycle → 0 one cycle later.
5. **Config edges:**
   - D=0 behaves as D=1: filtered changes 3 cycles after the pad.
   - Lowering D from 100 to 5 while the count is at 20 → transition next cycle.
   - `rise_en`=0 → filtered still changes, no pulse, no pending.
6. **Reset mid-check:** drop `rst_n` during `CHK_HI` of pin 3 → outputs 0 immediately, no pulse. After release with pad still high → rise 2+D cycles later.
